data_memory: RTL and testbench
==============================

# data_memory

Parametrised byte-addressed data memory for the datapath, serving load/store requests from the execute stage. It supports byte, halfword and full-word accesses, little-endian byte lanes, and sign or zero extension on loads. Requests use a valid/ready handshake, and every request gets a registered response with an error flag. After reset the block runs a sequential clear of every word; it accepts no requests until the clear completes.

## Interface
- DATA_W, 16, word width in bits; a multiple of 8 and at least 16.
- DEPTH, 256, number of words; a power of 2 and at least 2.
- ADDR_W, 16, byte-address width.
- clk  in  1  the only clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword (16 b), 10 word (DATA_W b), 11 illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, taken from the low-order bits.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- rsp_err  out  1  request was rejected (qualified by rsp_valid).
- init_busy  out  1  reset clear in progress.

## Operation
- **Address decode.**
  - BPW = DATA_W/8.
  - Word index = req_addr >> log2(BPW).
  - Byte offset = req_addr[log2(BPW)-1:0].
  - Byte k of a word occupies bits [8k+7:8k].
- **Accept.** A request is accepted on a cycle where req_valid && req_ready.
- **Errors.** rsp_err=1 if any of the following holds:
  - req_size is 11;
  - misaligned: a halfword needs offset a multiple of 2, a word needs offset 0;
  - word index ≥ DEPTH.
  - An erroring request never writes memory and returns rsp_rdata=0.
- **Store.** Writes only the addressed lanes and leaves all other lanes unchanged.
  - Byte: req_wdata[7:0] goes to lane offset.
  - Halfword: req_wdata[15:0] goes to lanes offset and offset+1.
  - Word: the whole word is written.
- **Load.** Selects the addressed lanes, right-justifies them, then extends to DATA_W.
  - Sign extension uses the top bit of the selected field when req_signed=1.
  - Zero extension is used when req_signed=0.
- **State machine.** Two states, INIT and RUN.
  - On reset: state=INIT, clear counter=0.
  - INIT with rst low: write 0 to word[counter] and increment the counter. On the edge that clears word DEPTH-1, go to RUN.
  - RUN: serve requests. Only rst leaves RUN.
- **Outputs.**
  - req_ready=1 only in RUN.
  - init_busy=1 only in INIT.
  - Both are registered.

## Timing
- **Reset values.**
  - req_ready=0, init_busy=1.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Memory contents are undefined until INIT finishes.
- **INIT length.** Takes exactly DEPTH cycles after the first edge with rst low. req_ready rises on the following cycle. While rst is held high, the counter stays at 0.
- **Latency.**
  - A request accepted at edge N has rsp_valid=1 and its data/err valid in cycle N+1, for both loads and stores.
  - rsp_valid is low in any cycle that follows no acceptance.
  - Response fields hold their values when rsp_valid=0.
- **Throughput.**
  - One request per cycle.
  - There is no response backpressure; the consumer must take the response the cycle it appears.
- **Back-to-back hazard.** A load accepted on the cycle right after a store to the same word returns the post-store data.
- **Same-cycle read/write.** A load never overlaps a store (single port, one request per cycle).
- **Reset mid-operation.**
  - rst high at any edge aborts the current operation.
  - The pending response is dropped: rsp_valid=0 on the next cycle.
  - The block returns to INIT and the full clear reruns.
- **Unaccepted requests.** req_valid while req_ready=0 is ignored and produces no response.

## Test plan
- **Reset/init (DEPTH=256).**
  - Stimulus: release rst, then hold req_valid=1.
  - Required: init_busy=1 for 256 cycles, req_ready rises in cycle 257, and no rsp_valid appears before acceptance.
  - Then load word at addr 0x01FE → rdata 0x0000, err 0.
- **Byte lanes (DATA_W=16).**
  - Stores: word 0xA55A to 0x0010, then byte 0x80 to 0x0011.
  - Unsigned word load of 0x0010 → 0x805A.
  - Signed byte load of 0x0011 → 0xFF80.
  - Unsigned byte load of 0x0011 → 0x0080.
- **Errors.** Each of the following returns err=1 and rdata 0, and a following load of word 0 is unchanged:
  - halfword store at 0x0003;
  - word load at 0x0201 (index ≥ DEPTH);
  - req_size=11.
- **Back-to-back.**
  - Stimulus: store 0x1234 to 0x0020 at cycle N, load 0x0020 at cycle N+1.
  - Required: response at N+2 is 0x1234; one rsp_valid per cycle with no gaps.
- **Reset mid-stream.**
  - Stimulus: assert rst the cycle after a store of 0xBEEF to 0x0004 is accepted.
  - Required: no rsp_valid on the next cycle, a full 256-cycle INIT reruns, and a load of 0x0004 then returns 0x0000.
- **Parameter sweep.**
  - Configuration: DATA_W=32, DEPTH=16.
  - Store 0x1234 as a halfword to 0x000E, then word-load 0x000C → 0x12340000.
  - Signed halfword load of 0x000C → 0x00000000.

Source files
------------

// File: rtl/data_memory.sv
// data_memory: byte-addressed, little-endian data memory with byte/halfword/word
// access, sign or zero extended loads and a one-cycle registered response.
// Out of reset it zeroes every word in turn and only then starts taking requests.
module data_memory #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_busy
);
    localparam int BPW   = DATA_W / 8;
    localparam int OFF_W = $clog2(BPW);
    localparam int IDX_W = ADDR_W - OFF_W;
    localparam int AW    = $clog2(DEPTH);

    // Handshake: a request is taken on any rising edge where req_valid and
    // req_ready are both high; req_ready does not depend on req_valid. Every
    // taken request, good or bad, produces exactly one rsp_valid pulse on the
    // next cycle. There is no response backpressure.

    typedef enum logic {INIT, RUN} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
    logic              ready_d, busy_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [OFF_W+2:0]  sh;
    logic              oob, misaligned, err, accept;
    logic [DATA_W-1:0] rd_word, lane_mask, lane_data, merged, shifted, load_val;

    assign off     = req_addr[OFF_W-1:0];
    assign idx     = req_addr[ADDR_W-1:OFF_W];
    assign sh      = {off, 3'b000};
    assign rd_word = mem[idx[AW-1:0]];
    assign accept  = req_valid & req_ready;

    // Word indices beyond the array are any set bit above the array index bits.
    generate
        if (IDX_W > AW) begin : g_oob
            assign oob = |idx[IDX_W-1:AW];
        end else begin : g_no_oob
            assign oob = 1'b0;
        end
    endgenerate

    // Alignment rule: halfwords on even offsets, words on offset zero.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = |off;
            default: misaligned = 1'b0;
        endcase
    end

    assign err = (req_size == 2'b11) | misaligned | oob;

    // Store lane mask/data and load lane select plus extension.
    always_comb begin
        lane_mask = '1;
        lane_data = req_wdata;
        shifted   = rd_word >> sh;
        load_val  = shifted;
        case (req_size)
            2'b00: begin
                lane_mask = DATA_W'(8'hFF) << sh;
                lane_data = DATA_W'(req_wdata[7:0]) << sh;
                load_val  = DATA_W'(shifted[7:0]);
                if (req_signed && shifted[7]) load_val = load_val | ~DATA_W'(8'hFF);
            end
            2'b01: begin
                lane_mask = DATA_W'(16'hFFFF) << sh;
                lane_data = DATA_W'(req_wdata[15:0]) << sh;
                load_val  = DATA_W'(shifted[15:0]);
                if (req_signed && shifted[15]) load_val = load_val | ~DATA_W'(16'hFFFF);
            end
            default: begin
                lane_mask = '1;
                lane_data = req_wdata;
                load_val  = shifted;
            end
        endcase
        merged = (rd_word & ~lane_mask) | (lane_data & lane_mask);
    end

    // Next state: walk the clear counter through every word, then serve requests.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            INIT: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(DEPTH - 1)) state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
        ready_d = (state_d == RUN);
        busy_d  = (state_d == INIT);
    end

    // State, clear counter and the registered ready/busy flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT;
            clr_cnt_q <= '0;
            req_ready <= 1'b0;
            init_busy <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            req_ready <= ready_d;
            init_busy <= busy_d;
        end
    end

    // Memory array: clear writes during INIT, lane-merged stores during RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == INIT) begin
                mem[clr_cnt_q] <= '0;
            end else if (accept && req_we && !err) begin
                mem[idx[AW-1:0]] <= merged;
            end
        end
    end

    // Response register: pulse valid per accepted request, hold data otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                rsp_err   <= err;
                rsp_rdata <= (err || req_we) ? '0 : load_val;
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: two instances (16-bit x 256 and 32-bit x 16) checked
// every cycle against a byte-array reference model, plus directed cases with
// hand-computed values.
module tb_data_memory;
    logic clk = 1'b0;
    logic rst = 1'b1;

    // clock: 10 ns period, first rising edge at 5 ns
    always #5 clk = ~clk;

    logic        a_valid, a_ready, a_we, a_signed, a_rv, a_err, a_busy;
    logic [1:0]  a_size;
    logic [15:0] a_addr, a_wdata, a_rdata;
    logic        b_valid, b_ready, b_we, b_signed, b_rv, b_err, b_busy;
    logic [1:0]  b_size;
    logic [15:0] b_addr;
    logic [31:0] b_wdata, b_rdata;

    data_memory #(.DATA_W(16), .DEPTH(256), .ADDR_W(16)) dut_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
        .req_size(a_size), .req_signed(a_signed), .req_addr(a_addr), .req_wdata(a_wdata),
        .rsp_valid(a_rv), .rsp_rdata(a_rdata), .rsp_err(a_err), .init_busy(a_busy));

    data_memory #(.DATA_W(32), .DEPTH(16), .ADDR_W(16)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
        .req_size(b_size), .req_signed(b_signed), .req_addr(b_addr), .req_wdata(b_wdata),
        .rsp_valid(b_rv), .rsp_rdata(b_rdata), .rsp_err(b_err), .init_busy(b_busy));

    int checks = 0;
    int errors = 0;

    // reference model state, index 0 = dut_a, 1 = dut_b
    logic [7:0]  bmem [2][1024];
    int          init_left [2];
    bit          m_ready [2], m_busy [2], m_rv [2], started [2];
    logic [64:0] hold_exp [2];
    logic [64:0] exp_qa [$];
    logic [64:0] exp_qb [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Byte-level access: memory is a flat byte array, words are BPW bytes.
    task automatic model_access(input int d, input logic we, input logic [1:0] sz, input logic sg,
                                input int addr, input logic [63:0] wd,
                                output logic e, output logic [63:0] rd);
        int bpw, depth, n;
        bpw   = (d == 0) ? 2 : 4;
        depth = (d == 0) ? 256 : 16;
        n     = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : bpw;
        e     = (sz == 2'b11) || (addr % n != 0) || (addr / bpw >= depth);
        rd    = '0;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < n; i++) bmem[d][addr + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) rd[8*i +: 8] = bmem[d][addr + i];
                if (sg && rd[8*n - 1])
                    for (int k = 8*n; k < 8*bpw; k++) rd[k] = 1'b1;
            end
        end
    endtask

    // Cycle-level behaviour: reset, DEPTH cycles of clearing, then one request per cycle.
    task automatic model_edge(input int d, input logic r, input logic v, input logic we,
                              input logic [1:0] sz, input logic sg, input logic [15:0] addr,
                              input logic [63:0] wd);
        logic        e;
        logic [63:0] rd;
        if (r) begin
            started[d]   = 1'b1;
            init_left[d] = (d == 0) ? 256 : 16;
            m_ready[d]   = 1'b0;
            m_busy[d]    = 1'b1;
            m_rv[d]      = 1'b0;
            hold_exp[d]  = '0;
            if (d == 0) exp_qa.delete(); else exp_qb.delete();
            for (int i = 0; i < 1024; i++) bmem[d][i] = 8'h00;
        end else if (started[d] && init_left[d] > 0) begin
            init_left[d]--;
            m_rv[d] = 1'b0;
            if (init_left[d] == 0) begin
                m_ready[d] = 1'b1;
                m_busy[d]  = 1'b0;
            end
        end else if (started[d]) begin
            m_rv[d] = v && m_ready[d];
            if (m_rv[d]) begin
                model_access(d, we, sz, sg, int'(addr), wd, e, rd);
                if (d == 0) exp_qa.push_back({e, rd}); else exp_qb.push_back({e, rd});
            end
        end
    endtask

    // model advances on the same edge the DUT samples
    always @(posedge clk) begin
        model_edge(0, rst, a_valid, a_we, a_size, a_signed, a_addr, 64'(a_wdata));
        model_edge(1, rst, b_valid, b_we, b_size, b_signed, b_addr, 64'(b_wdata));
    end

    task automatic cmp(input int d, input logic ready, input logic busy, input logic rv,
                       input logic err, input logic [63:0] rdata);
        if (!started[d]) return;
        if (m_rv[d]) begin
            if (d == 0 && exp_qa.size() > 0) hold_exp[d] = exp_qa.pop_front();
            if (d == 1 && exp_qb.size() > 0) hold_exp[d] = exp_qb.pop_front();
        end
        check($sformatf("dut%0d req_ready", d), 64'(ready), 64'(m_ready[d]));
        check($sformatf("dut%0d init_busy", d), 64'(busy), 64'(m_busy[d]));
        check($sformatf("dut%0d rsp_valid", d), 64'(rv), 64'(m_rv[d]));
        check($sformatf("dut%0d rsp_err", d), 64'(err), 64'(hold_exp[d][64]));
        check($sformatf("dut%0d rsp_rdata", d), rdata, hold_exp[d][63:0]);
    endtask

    // scoreboard compare on the falling edge, away from the sampling edge
    always @(negedge clk) begin
        cmp(0, a_ready, a_busy, a_rv, a_err, 64'(a_rdata));
        cmp(1, b_ready, b_busy, b_rv, b_err, 64'(b_rdata));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int d, input logic v, input logic we, input logic [1:0] sz,
                           input logic sg, input logic [15:0] addr, input logic [63:0] wd);
        if (d == 0) begin
            a_valid = v; a_we = we; a_size = sz; a_signed = sg; a_addr = addr; a_wdata = wd[15:0];
        end else begin
            b_valid = v; b_we = we; b_size = sz; b_signed = sg; b_addr = addr; b_wdata = wd[31:0];
        end
    endtask

    task automatic sample(input int d, output logic ready, output logic busy, output logic rv,
                          output logic err, output logic [63:0] rdata);
        if (d == 0) begin
            ready = a_ready; busy = a_busy; rv = a_rv; err = a_err; rdata = 64'(a_rdata);
        end else begin
            ready = b_ready; busy = b_busy; rv = b_rv; err = b_err; rdata = 64'(b_rdata);
        end
    endtask

    task automatic wait_ready(input int d);
        logic r, b, v, e;
        logic [63:0] x;
        for (int i = 0; i < 600; i++) begin
            sample(d, r, b, v, e, x);
            if (r === 1'b1) break;
            step();
        end
        sample(d, r, b, v, e, x);
        check($sformatf("dut%0d ready wait", d), 64'(r), 64'd1);
    endtask

    // Count busy cycles from just after reset release until ready rises.
    task automatic count_init(input int d, input int exp_cycles);
        logic r, b, v, e;
        logic [63:0] x;
        int n = 0;
        for (int c = 0; c < 400; c++) begin
            sample(d, r, b, v, e, x);
            if (r === 1'b1) break;
            if (b === 1'b1) n++;
            step();
        end
        sample(d, r, b, v, e, x);
        check($sformatf("dut%0d init cycles", d), 64'(n), 64'(exp_cycles));
        check($sformatf("dut%0d ready after init", d), 64'(r), 64'd1);
        check($sformatf("dut%0d busy after init", d), 64'(b), 64'd0);
    endtask

    // One request with literal expectations, also pinned against the model.
    task automatic req(input int d, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [15:0] addr, input logic [63:0] wd,
                       input logic [63:0] exp_rd, input logic exp_err, input string name);
        logic r, b, v, e;
        logic [63:0] x;
        logic [64:0] m;
        wait_ready(d);
        set_req(d, 1'b1, we, sz, sg, addr, wd);
        step();
        set_req(d, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 64'h0);
        sample(d, r, b, v, e, x);
        check({name, " rsp_valid"}, 64'(v), 64'd1);
        check({name, " rdata"}, x, exp_rd);
        check({name, " err"}, 64'(e), 64'(exp_err));
        m = '0;
        if (d == 0 && exp_qa.size() > 0) m = exp_qa[$];
        if (d == 1 && exp_qb.size() > 0) m = exp_qb[$];
        check({name, " model"}, m[63:0] ^ {63'd0, m[64]}, exp_rd ^ {63'd0, exp_err});
    endtask

    task automatic rand_req(input int d);
        logic [1:0] sz;
        int bpw, n, addr;
        bpw  = (d == 0) ? 2 : 4;
        sz   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : bpw;
        if (d == 0)
            addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 'h27F)) : int'($urandom_range(0, 31));
        else
            addr = int'($urandom_range(0, 79));
        if ($urandom_range(0, 2) != 0) addr = addr - addr % n;
        set_req(d, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), sz,
                1'($urandom_range(0, 1)), 16'(addr), {$urandom, $urandom});
    endtask

    logic        r_s, b_s, v_s, e_s;
    logic [63:0] x_s;

    initial begin
        set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 64'h0);
        set_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 64'h0);
        rst = 1'b1;
        repeat (3) step();
        sample(0, r_s, b_s, v_s, e_s, x_s);
        check("reset ready", 64'(r_s), 64'd0);
        check("reset busy", 64'(b_s), 64'd1);
        check("reset rsp_valid", 64'(v_s), 64'd0);
        check("reset rdata", x_s, 64'd0);
        rst = 1'b0;

        // reset/init with a load held pending the whole time
        set_req(0, 1'b1, 1'b0, 2'b10, 1'b0, 16'h01FE, 64'h0);
        count_init(0, 256);
        req(0, 1'b0, 2'b10, 1'b0, 16'h01FE, 64'h0, 64'h0000, 1'b0, "init load");

        // byte lanes
        req(0, 1'b1, 2'b10, 1'b0, 16'h0010, 64'hA55A, 64'h0, 1'b0, "st word");
        req(0, 1'b1, 2'b00, 1'b0, 16'h0011, 64'h0080, 64'h0, 1'b0, "st byte");
        req(0, 1'b0, 2'b10, 1'b0, 16'h0010, 64'h0, 64'h805A, 1'b0, "ld word");
        req(0, 1'b0, 2'b00, 1'b1, 16'h0011, 64'h0, 64'hFF80, 1'b0, "ld sbyte");
        req(0, 1'b0, 2'b00, 1'b0, 16'h0011, 64'h0, 64'h0080, 1'b0, "ld ubyte");
        req(0, 1'b0, 2'b00, 1'b1, 16'h0010, 64'h0, 64'h005A, 1'b0, "ld sbyte pos");

        // errors never write and return zero
        req(0, 1'b1, 2'b01, 1'b0, 16'h0003, 64'hDEAD, 64'h0, 1'b1, "hw st mis");
        req(0, 1'b1, 2'b01, 1'b0, 16'h0001, 64'hDEAD, 64'h0, 1'b1, "hw st mis w0");
        req(0, 1'b0, 2'b10, 1'b0, 16'h0201, 64'h0, 64'h0, 1'b1, "ld oob");
        req(0, 1'b1, 2'b10, 1'b0, 16'h0200, 64'h7777, 64'h0, 1'b1, "st oob");
        req(0, 1'b1, 2'b11, 1'b0, 16'h0000, 64'hFFFF, 64'h0, 1'b1, "st size11");
        req(0, 1'b0, 2'b11, 1'b0, 16'h0010, 64'h0, 64'h0, 1'b1, "ld size11");
        req(0, 1'b0, 2'b10, 1'b0, 16'h0000, 64'h0, 64'h0000, 1'b0, "w0 unchanged");
        req(0, 1'b0, 2'b10, 1'b0, 16'h0010, 64'h0, 64'h805A, 1'b0, "w8 unchanged");

        // back-to-back store then load of the same word
        wait_ready(0);
        set_req(0, 1'b1, 1'b1, 2'b10, 1'b0, 16'h0020, 64'h1234);
        step();
        set_req(0, 1'b1, 1'b0, 2'b10, 1'b0, 16'h0020, 64'h0);
        sample(0, r_s, b_s, v_s, e_s, x_s);
        check("b2b store rsp_valid", 64'(v_s), 64'd1);
        check("b2b store rdata", x_s, 64'd0);
        step();
        set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 64'h0);
        sample(0, r_s, b_s, v_s, e_s, x_s);
        check("b2b load rsp_valid", 64'(v_s), 64'd1);
        check("b2b load rdata", x_s, 64'h1234);
        step();
        sample(0, r_s, b_s, v_s, e_s, x_s);
        check("b2b idle rsp_valid", 64'(v_s), 64'd0);
        check("b2b hold rdata", x_s, 64'h1234);

        // reset mid-stream drops the pending work and reruns the clear
        wait_ready(0);
        set_req(0, 1'b1, 1'b1, 2'b10, 1'b0, 16'h0004, 64'hBEEF);
        step();
        set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 64'h0);
        rst = 1'b1;
        step();
        sample(0, r_s, b_s, v_s, e_s, x_s);
        check("mid reset rsp_valid", 64'(v_s), 64'd0);
        check("mid reset ready", 64'(r_s), 64'd0);
        check("mid reset busy", 64'(b_s), 64'd1);
        rst = 1'b0;
        count_init(0, 256);
        req(0, 1'b0, 2'b10, 1'b0, 16'h0004, 64'h0, 64'h0000, 1'b0, "post reset ld");

        // 32-bit x 16 configuration
        req(1, 1'b1, 2'b01, 1'b0, 16'h000E, 64'h1234, 64'h0, 1'b0, "b st hw");
        req(1, 1'b0, 2'b10, 1'b0, 16'h000C, 64'h0, 64'h12340000, 1'b0, "b ld word");
        req(1, 1'b0, 2'b01, 1'b1, 16'h000C, 64'h0, 64'h00000000, 1'b0, "b ld shw lo");
        req(1, 1'b0, 2'b01, 1'b1, 16'h000E, 64'h0, 64'h00001234, 1'b0, "b ld shw hi");
        req(1, 1'b1, 2'b00, 1'b0, 16'h000D, 64'h9A, 64'h0, 1'b0, "b st byte");
        req(1, 1'b0, 2'b01, 1'b1, 16'h000C, 64'h0, 64'hFFFF9A00, 1'b0, "b ld shw neg");
        req(1, 1'b0, 2'b01, 1'b0, 16'h000C, 64'h0, 64'h00009A00, 1'b0, "b ld uhw");
        req(1, 1'b0, 2'b10, 1'b0, 16'h0040, 64'h0, 64'h0, 1'b1, "b ld oob");
        req(1, 1'b0, 2'b10, 1'b0, 16'h000E, 64'h0, 64'h0, 1'b1, "b ld mis");

        // random traffic on both instances, checked by the scoreboard
        for (int i = 0; i < 2000; i++) begin
            rand_req(0);
            rand_req(1);
            step();
        end
        set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 64'h0);
        set_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 64'h0);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
